// File: rtl/vedic_seq_mul_ctrl.sv
// Sequenced 8x8 unsigned multiplier: one Vedic 4x4 core reused over four cycles,
// with valid/ready handshakes on the operand and result sides.

module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c1;

  always_comb begin
    c1   = (a[1] & b[0]) & (a[0] & b[1]);
    p[0] = a[0] & b[0];
    p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    p[2] = (a[1] & b[1]) ^ c1;
    p[3] = (a[1] & b[1]) & c1;
  end
endmodule

module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;

  vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

  always_comb begin
    p = {4'b0000, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00} + {q3, 4'b0000};
  end
endmodule

module vedic_seq_mul_ctrl #(
  parameter bit          ZERO_SKIP = 1'b1,
  parameter int unsigned OP_CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          a,
  input  logic [7:0]          b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         result,
  output logic                busy,
  output logic [OP_CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t              state, state_next;
  logic [1:0]          step;
  logic [15:0]         acc;
  logic [7:0]          a_r, b_r;
  logic [OP_CNT_W-1:0] op_count_r;
  logic [3:0]          mul_a, mul_b;
  logic [7:0]          pp;
  logic [15:0]         pp_shifted;
  logic                accept, handoff, zero_hit;

  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;
  assign zero_hit = ZERO_SKIP && ((a == 8'd0) || (b == 8'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = zero_hit ? DONE : MUL;
      MUL:  if (step == 2'd3) state_next = DONE;
      DONE: if (handoff) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Step order: lo*lo, hi*lo, lo*hi, hi*hi; shift follows the nibble weights.
  always_comb begin
    mul_a      = step[0] ? a_r[7:4] : a_r[3:0];
    mul_b      = step[1] ? b_r[7:4] : b_r[3:0];
    pp_shifted = '0;
    unique case (step)
      2'd0:    pp_shifted = {8'h00, pp};
      2'd1,
      2'd2:    pp_shifted = {4'h0, pp, 4'h0};
      default: pp_shifted = {pp, 8'h00};
    endcase
  end

  vedic_4x4 u_core (.a(mul_a), .b(mul_b), .p(pp));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r  <= '0;
      b_r  <= '0;
      acc  <= '0;
      step <= '0;
    end else if (accept) begin
      a_r  <= a;
      b_r  <= b;
      acc  <= '0;
      step <= '0;
    end else if (state == MUL) begin
      acc  <= acc + pp_shifted;
      step <= step + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      op_count_r <= '0;
    else if (handoff && (op_count_r != '1))
      op_count_r <= op_count_r + {{(OP_CNT_W-1){1'b0}}, 1'b1};
  end

  assign result   = acc;
  assign op_count = op_count_r;
endmodule

// File: tb/tb_vedic_seq_mul_ctrl.sv
// Directed bench for vedic_seq_mul_ctrl: default instance, a no-skip instance and a
// 4-bit op_count instance (driven in lockstep with the default one).

module tb_vedic_seq_mul_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [15:0] result;
  logic [15:0] op_count;

  logic        s_in_ready, s_out_valid, s_busy;
  logic [15:0] s_result;
  logic [3:0]  s_op_count;

  logic        ns_in_valid = 1'b0;
  logic [7:0]  ns_a = '0, ns_b = '0;
  logic        ns_out_ready = 1'b1;
  logic        ns_in_ready, ns_out_valid, ns_busy;
  logic [15:0] ns_result;
  logic [15:0] ns_op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vedic_seq_mul_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy),
    .op_count(op_count)
  );

  vedic_seq_mul_ctrl #(.OP_CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b),
    .out_valid(s_out_valid), .out_ready(out_ready), .result(s_result), .busy(s_busy),
    .op_count(s_op_count)
  );

  vedic_seq_mul_ctrl #(.ZERO_SKIP(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(ns_in_valid), .in_ready(ns_in_ready), .a(ns_a),
    .b(ns_b), .out_valid(ns_out_valid), .out_ready(ns_out_ready), .result(ns_result),
    .busy(ns_busy), .op_count(ns_op_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat = edges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic do_op(input logic [7:0] xa, input logic [7:0] xb,
                       output int lat, output logic [15:0] res);
    int guard = 0;
    while (!in_ready && guard < 20) begin tick(); guard++; end
    in_valid = 1'b1; a = xa; b = xb;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    if (!out_valid) lat = -1;
    res = result;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'd0 ||
        op_count !== 16'd0 || s_op_count !== 4'd0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b result=%0d op_count=%0d sat=%0d, required 1 0 0 0 0 0",
               in_ready, out_valid, busy, result, op_count, s_op_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'd200; b = 8'd190;
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_mul_state: busy=%b in_ready=%b out_valid=%b, required 1 0 0", busy, in_ready, out_valid);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges, required 4", lat);
    end
    checks++;
    if (result !== 16'd38000) begin
      errors++;
      $display("FAIL basic_result: got %0d, required 38000", result);
    end
    tick();
    checks++;
    if (op_count !== 16'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handoff: op_count=%0d out_valid=%b in_ready=%b, required 1 0 1", op_count, out_valid, in_ready);
    end
  endtask

  task automatic test_extremes();
    int lat;
    logic [15:0] res;
    do_op(8'd255, 8'd255, lat, res);
    checks++;
    if (res !== 16'd65025 || lat !== 4) begin
      errors++;
      $display("FAIL max_operands: result=%0d lat=%0d, required 65025 4", res, lat);
    end
    do_op(8'd1, 8'd1, lat, res);
    checks++;
    if (res !== 16'd1 || lat !== 4) begin
      errors++;
      $display("FAIL unit_operands: result=%0d lat=%0d, required 1 4", res, lat);
    end
  endtask

  task automatic test_zero_skip();
    int lat;
    logic [15:0] res;
    do_op(8'd0, 8'd123, lat, res);
    checks++;
    if (res !== 16'd0 || lat !== 0) begin
      errors++;
      $display("FAIL zero_skip: result=%0d lat=%0d, required 0 0", res, lat);
    end
    do_op(8'd77, 8'd0, lat, res);
    checks++;
    if (res !== 16'd0 || lat !== 0) begin
      errors++;
      $display("FAIL zero_skip_b: result=%0d lat=%0d, required 0 0", res, lat);
    end
    ns_in_valid = 1'b1; ns_a = 8'd0; ns_b = 8'd123;
    tick();
    ns_in_valid = 1'b0;
    lat = 0;
    while (!ns_out_valid && lat < 20) begin tick(); lat++; end
    checks++;
    if (ns_result !== 16'd0 || lat !== 4) begin
      errors++;
      $display("FAIL no_zero_skip: result=%0d lat=%0d, required 0 4", ns_result, lat);
    end
    tick();
  endtask

  task automatic test_stall();
    int lat;
    logic [15:0] cnt0;
    cnt0 = op_count;
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'd144; b = 8'd89;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = ~a; b = b + 8'd37;
      tick(); lat++;
    end
    checks++;
    if (out_valid !== 1'b1 || result !== 16'd12816) begin
      errors++;
      $display("FAIL stall_result: out_valid=%b result=%0d, required 1 12816", out_valid, result);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || result !== 16'd12816 || op_count !== cnt0) begin
        errors++;
        $display("FAIL stall_hold%0d: out_valid=%b result=%0d op_count=%0d, required 1 12816 %0d",
                 i, out_valid, result, op_count, cnt0);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || op_count !== cnt0 + 16'd1) begin
      errors++;
      $display("FAIL stall_release: out_valid=%b op_count=%0d, required 0 %0d", out_valid, op_count, cnt0 + 16'd1);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    logic [15:0] res;
    in_valid = 1'b1; a = 8'd249; b = 8'd153;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || result !== 16'd0 ||
        op_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b busy=%b out_valid=%b result=%0d op_count=%0d, required 1 0 0 0 0",
               in_ready, busy, out_valid, result, op_count);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_valid: out_valid seen %0d cycles, required 0", seen);
    end
    do_op(8'd2, 8'd223, lat, res);
    checks++;
    if (res !== 16'd446 || lat !== 4 || op_count !== 16'd1) begin
      errors++;
      $display("FAIL after_reset_op: result=%0d lat=%0d op_count=%0d, required 446 4 1", res, lat, op_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    logic [15:0] exp;
    int sent = 0, got = 0, cyc = 0;
    bit have_pair = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    while ((got < 500) && (cyc < 20000)) begin
      if (!have_pair && sent < 500) begin
        a = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
        b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
        have_pair = 1;
      end
      in_valid  = have_pair;
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        exp = exp_q.pop_front();
        got++;
        checks++;
        if (result !== exp) begin
          errors++;
          $display("FAIL stream_result #%0d: got %0d, required %0d", got, result, exp);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(16'(a) * 16'(b));
        sent++;
        have_pair = 0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 500) begin
      errors++;
      $display("FAIL stream_timeout: got %0d results, required 500", got);
    end
    checks++;
    if (op_count !== 16'd500) begin
      errors++;
      $display("FAIL stream_op_count: got %0d, required 500", op_count);
    end
    checks++;
    if (s_op_count !== 4'd15) begin
      errors++;
      $display("FAIL op_count_saturate: got %0d, required 15", s_op_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_zero_skip();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
